wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-stage arbiter that sits directly upstream of the register file write port (we/waddr/wdata).
- Merges results from the single-cycle ALU pipe and the multi-cycle MUL/DIV unit (MDU) into one registered write per cycle.
- MDU results are buffered in a small in-order queue.
- Resolves WAW ordering between the two producers and exports a per-register pending vector to the issue/hazard logic.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- QDEPTH, 4, MDU result queue depth; power of two, minimum 2

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid this cycle; no back-pressure, ALU always accepted
- alu_waddr  in  ADDR_W  ALU destination register
- alu_wdata  in  DATA_W  ALU result
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  queue can accept; transfer when mdu_valid & mdu_ready
- mdu_waddr  in  ADDR_W  MDU destination register
- mdu_wdata  in  DATA_W  MDU result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- pending  out  2**ADDR_W  bit r set while a live queued write targets register r
- alu_stall  out  1  request to hold ALU issue for one cycle (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, alu_stall=0.
  - Queue emptied; all entries dropped.
  - mdu_ready=0 while rst=1.
  - Reset mid-operation discards queued results without writing them.
- mdu_ready = !rst & !full, where full is registered queue state.
  - No enqueue when full, even if a dequeue occurs the same cycle.
- Queue entry holds {live, waddr, wdata}. Enqueue on an mdu handshake. Entries with mdu_waddr=0 are accepted but enqueued dead.
- Selection each cycle, priority order:
  1. alu_valid & alu_waddr!=0 → issue ALU.
  2. Else head live → issue head and pop.
  3. Else nothing.
- A dead head is popped in any cycle, including ALU-issue cycles, with no write.
- Issued write appears on rf_* one cycle after selection (latency 1).
  - rf_we deasserts in any cycle with no issue.
  - rf_waddr/rf_wdata hold their last value when rf_we=0.
- Writes to register 0 never assert rf_we.
- WAW rule (the ALU result is always program-order younger than any MDU result):
  - An ALU issue to X clears live on every queued entry with waddr X.
  - A same-cycle incoming MDU entry with waddr X is enqueued dead.
- pending[r] = OR over live entries of (waddr==r). It reflects queue state after the current edge (registered). pending[0] is always 0.
- Queue pointers: ADDR width log2(QDEPTH)+1 with wrap bit. Full/empty derive from pointer compare; wrap-around is exercised by the tests.
- Simultaneous enqueue and pop when non-full, non-empty: occupancy unchanged.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - 3-bit counter increments each cycle a live head is blocked by an ALU issue; it clears on any head pop or on rst.
  - When the counter reaches 7, alu_stall=1 for exactly one cycle (registered) and the counter clears.
  - Upstream holds the ALU that cycle (alu_valid=0), so the head drains.
- Undefined: alu_stall tied 0; no counter; the queue may starve under continuous ALU traffic (accepted).

Decomposition:
- Package cpu_wb_pkg:
  - constants DATA_W/ADDR_W defaults and NREGS=2**ADDR_W;
  - typedef wb_entry_t {logic live; logic [ADDR_W-1:0] waddr; logic [DATA_W-1:0] wdata};
  - typedef wb_req_t {valid, waddr, wdata}.
- One sub-module: wb_fifo (QDEPTH-entry queue of wb_entry_t, with a per-entry kill-by-address input and a live-address vector output).
- Arbitration, output register and starvation guard stay in wb_arbiter.

Test Plan:
- Reset: assert rst 2 cycles with mdu_valid=1 → rf_we=0, pending=0, mdu_ready=0. Release → mdu_ready=1 next cycle.
- ALU only: alu_valid=1, waddr=5, wdata=0xDEADBEEF → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. waddr=0 → rf_we stays 0.
- Queue fill/wrap:
  - 4 MDU results (regs 8..11) while alu_valid=1 to regs 20..23 → mdu_ready drops after 4th accept; pending=0x00000F00.
  - Drop alu_valid → regs 8,9,10,11 written on 4 consecutive cycles; pending clears bit by bit.
  - Repeat 3× for pointer wrap.
- WAW kill: queue MDU {reg 7, 0x111}, then ALU {reg 7, 0x222} before drain → only 0x222 written to reg 7; pending[7] clears the cycle after the ALU issue.
- Same-cycle conflict: mdu_valid and alu_valid both to reg 3 (0xAAA / 0xBBB) → single write 0xBBB; the dead entry is popped with no write.
- WB_STARVE_GUARD_EN: 1 queued entry plus continuous alu_valid → alu_stall pulses once after 7 blocked cycles. With ALU held, head written next cycle. Undefined build → alu_stall stays 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and payload types for the writeback arbiter slice.
package cpu_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32'd1 << ADDR_W;

    // One queued MDU result; live=0 marks an entry to drop without writing.
    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    // A candidate register-file write.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/register-file side bundle of the writeback arbiter.
interface wb_arbiter_if;
    import cpu_wb_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_waddr;
    logic [DATA_W-1:0] mdu_wdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREGS-1:0]  pending;
    logic              alu_stall;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        output mdu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output pending, alu_stall
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        input  mdu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  pending, alu_stall
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// In-order MDU result queue with kill-by-address and a live-destination vector.
module wb_fifo
    import cpu_wb_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              kill_valid,
    input  logic [ADDR_W-1:0] kill_addr,
    output wb_entry_t         head,
    output logic              empty,
    output logic              full,
    output logic [NREGS-1:0]  live_vec
);

    localparam int unsigned IDX_W = $clog2(QDEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    wb_entry_t          mem_q [QDEPTH];
    wb_entry_t          mem_d [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Next queue state: kill matching entries, retire head, append new entry.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill_valid) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (mem_q[IDX_W'(i)].waddr == kill_addr) begin
                    mem_d[IDX_W'(i)].live = 1'b0;
                end
            end
        end
        // Popped slots are marked dead so live_vec can scan every slot.
        if (pop && !empty) begin
            mem_d[rd_ptr_q[IDX_W-1:0]].live = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !full) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    // Queue storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[IDX_W'(i)] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[IDX_W'(i)] <= mem_d[IDX_W'(i)];
            end
        end
    end

    // Destination decode of every live slot; register 0 never reported.
    always_comb begin
        live_vec = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (mem_q[IDX_W'(i)].live) begin
                live_vec[mem_q[IDX_W'(i)].waddr] = 1'b1;
            end
        end
        live_vec[0] = 1'b0;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and queued MDU results into one registered
// register-file write per cycle and tracks pending MDU destinations.
// Optional macro WB_STARVE_GUARD_EN adds an ALU stall pulse that lets a
// starved MDU queue head drain.
module wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_entry_t          fifo_head;
    wb_entry_t          push_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic [NREGS-1:0]   live_vec;
    logic               mdu_ready_c;
    logic               head_live;
    logic               head_dead;
    logic               mdu_issue;
    wb_req_t            alu_req;
    wb_req_t            sel_req;

    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

    assign mdu_ready_c = !rst && !fifo_full;

    wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill_valid (alu_req.valid),
        .kill_addr  (bus.alu_waddr),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .live_vec   (live_vec)
    );

    // Arbitration: ALU first, then a live head; dead heads always retire.
    always_comb begin
        alu_req.valid = bus.alu_valid && (bus.alu_waddr != '0);
        alu_req.waddr = bus.alu_waddr;
        alu_req.wdata = bus.alu_wdata;

        head_live = !fifo_empty && fifo_head.live;
        head_dead = !fifo_empty && !fifo_head.live;
        mdu_issue = !alu_req.valid && head_live;
        fifo_pop  = mdu_issue || head_dead;
        fifo_push = bus.mdu_valid && mdu_ready_c;

        // A same-cycle ALU write to the same register is younger: drop MDU.
        push_entry.live  = (bus.mdu_waddr != '0) &&
                           !(alu_req.valid && (bus.alu_waddr == bus.mdu_waddr));
        push_entry.waddr = bus.mdu_waddr;
        push_entry.wdata = bus.mdu_wdata;

        sel_req = alu_req;
        if (!alu_req.valid) begin
            sel_req.valid = mdu_issue;
            sel_req.waddr = fifo_head.waddr;
            sel_req.wdata = fifo_head.wdata;
        end
    end

    // Output register next state; address/data hold when idle.
    always_comb begin
        rf_we_d    = sel_req.valid;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (sel_req.valid) begin
            rf_waddr_d = sel_req.waddr;
            rf_wdata_d = sel_req.wdata;
        end
    end

    // Register-file write port register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.mdu_ready = mdu_ready_c;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.pending   = live_vec;

`ifdef WB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       alu_stall_q, alu_stall_d;

    // Count cycles a live head loses to the ALU; the 7th raises a stall pulse.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        alu_stall_d  = 1'b0;
        if (fifo_pop) begin
            starve_cnt_d = '0;
        end else if (alu_req.valid && head_live) begin
            if (starve_cnt_q == 3'd6) begin
                starve_cnt_d = '0;
                alu_stall_d  = 1'b1;
            end else begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end
    end

    // Starvation counter and stall pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
        end
    end

    assign bus.alu_stall = alu_stall_q;
`else
    assign bus.alu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus multi-cycle sequences.
module tb_wb_arbiter;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] pend;
    } vec_t;

    logic clk;
    logic rst;
    int   nchk;
    int   nerr;
    vec_t vecs[$];

    wb_arbiter_if bus();

    wb_arbiter #(.QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_waddr = aa;
        bus.alu_wdata = ad;
        bus.mdu_valid = mv;
        bus.mdu_waddr = ma;
        bus.mdu_wdata = md;
    endtask

    task automatic add_vec(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic mv, input logic [4:0] ma, input logic [31:0] md,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic rdy, input logic [31:0] pend);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.we = we; v.wa = wa; v.wd = wd;
        v.rdy = rdy; v.pend = pend;
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string nm, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [31:0] pend);
        chk({nm, ".we"},    32'(bus.rf_we),    32'(we));
        chk({nm, ".waddr"}, 32'(bus.rf_waddr), 32'(wa));
        chk({nm, ".wdata"}, bus.rf_wdata,      wd);
        chk({nm, ".pend"},  bus.pending,       pend);
    endtask

    initial begin
        logic [31:0] fill_pend  [4];
        logic [31:0] drain_pend [4];
        logic [31:0] mdat;
        logic [31:0] adat;
        nchk = 0;
        nerr = 0;
        fill_pend  = '{32'h0000_0100, 32'h0000_0300, 32'h0000_0700, 32'h0000_0F00};
        drain_pend = '{32'h0000_0E00, 32'h0000_0C00, 32'h0000_0800, 32'h0000_0000};

        // ---------------- vector table ----------------
        add_vec(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 5'd5, 32'hDEADBEEF, 1, 32'h0);
        add_vec(1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0,  0, 5'd5, 32'hDEADBEEF, 1, 32'h0);
        add_vec(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd5, 32'hDEADBEEF, 1, 32'h0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                adat = 32'hB000_0000 + 32'(r * 16) + 32'(20 + i);
                mdat = 32'hA000_0000 + 32'(r * 16) + 32'(8 + i);
                add_vec(1, 5'(20 + i), adat, 1, 5'(8 + i), mdat,
                        1, 5'(20 + i), adat, (i < 3), fill_pend[i]);
            end
            adat = 32'hB000_0000 + 32'(r * 16) + 32'd24;
            add_vec(1, 5'd24, adat, 1, 5'd12, 32'hFFFF_FFFF,
                    1, 5'd24, adat, 0, 32'h0000_0F00);
            for (int j = 0; j < 4; j++) begin
                mdat = 32'hA000_0000 + 32'(r * 16) + 32'(8 + j);
                add_vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                        1, 5'(8 + j), mdat, 1, drain_pend[j]);
            end
            mdat = 32'hA000_0000 + 32'(r * 16) + 32'd11;
            add_vec(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd11, mdat, 1, 32'h0);
        end
        // simultaneous enqueue and dequeue, then an MDU write to r0
        add_vec(1, 5'd20, 32'hC0, 1, 5'd8,  32'hC8,  1, 5'd20, 32'hC0, 1, 32'h0000_0100);
        add_vec(0, 5'd0,  32'h0,  1, 5'd9,  32'hC9,  1, 5'd8,  32'hC8, 1, 32'h0000_0200);
        add_vec(0, 5'd0,  32'h0,  1, 5'd10, 32'hCA,  1, 5'd9,  32'hC9, 1, 32'h0000_0400);
        add_vec(0, 5'd0,  32'h0,  0, 5'd0,  32'h0,   1, 5'd10, 32'hCA, 1, 32'h0);
        add_vec(0, 5'd0,  32'h0,  0, 5'd0,  32'h0,   0, 5'd10, 32'hCA, 1, 32'h0);
        add_vec(0, 5'd0,  32'h0,  1, 5'd0,  32'h55,  0, 5'd10, 32'hCA, 1, 32'h0);
        add_vec(0, 5'd0,  32'h0,  0, 5'd0,  32'h0,   0, 5'd10, 32'hCA, 1, 32'h0);

        // ---------------- reset ----------------
        rst = 1'b1;
        apply(0, 5'd0, 32'h0, 1, 5'd9, 32'h99);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_out($sformatf("rst%0d", k), 1'b0, 5'd0, 32'h0, 32'h0);
            chk($sformatf("rst%0d.ready", k), 32'(bus.mdu_ready), 32'h0);
            chk($sformatf("rst%0d.stall", k), 32'(bus.alu_stall), 32'h0);
        end
        rst = 1'b0;
        apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #1;
        chk("rel.ready", 32'(bus.mdu_ready), 32'h1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            apply(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            tick();
            chk_out($sformatf("row%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pend);
            chk($sformatf("row%0d.ready", i), 32'(bus.mdu_ready), 32'(vecs[i].rdy));
        end

        // ---------------- WAW kill ----------------
        apply(1, 5'd1, 32'h1, 1, 5'd7, 32'h111);
        tick();
        chk_out("waw0", 1'b1, 5'd1, 32'h1, 32'h0000_0080);
        apply(1, 5'd7, 32'h222, 0, 5'd0, 32'h0);
        tick();
        chk_out("waw1", 1'b1, 5'd7, 32'h222, 32'h0);
        apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick();
        chk_out("waw2", 1'b0, 5'd7, 32'h222, 32'h0);
        tick();
        chk_out("waw3", 1'b0, 5'd7, 32'h222, 32'h0);

        // ---------------- same-cycle conflict ----------------
        apply(1, 5'd3, 32'hBBB, 1, 5'd3, 32'hAAA);
        tick();
        chk_out("cfl0", 1'b1, 5'd3, 32'hBBB, 32'h0);
        apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick();
        chk_out("cfl1", 1'b0, 5'd3, 32'hBBB, 32'h0);
        tick();
        chk_out("cfl2", 1'b0, 5'd3, 32'hBBB, 32'h0);

        // ---------------- starvation guard ----------------
        apply(1, 5'd1, 32'h10, 1, 5'd6, 32'h66);
        tick();
        chk_out("stv0", 1'b1, 5'd1, 32'h10, 32'h0000_0040);
        chk("stv0.stall", 32'(bus.alu_stall), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            apply(1, 5'd2, 32'h20 + 32'(k), 0, 5'd0, 32'h0);
            tick();
            chk_out($sformatf("stv%0d", k), 1'b1, 5'd2, 32'h20 + 32'(k), 32'h0000_0040);
            chk($sformatf("stv%0d.stall", k), 32'(bus.alu_stall), 32'((k == 7) && GUARD));
        end
        apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick();
        chk_out("stv8", 1'b1, 5'd6, 32'h66, 32'h0);
        chk("stv8.stall", 32'(bus.alu_stall), 32'h0);

        // ---------------- reset mid-operation ----------------
        apply(1, 5'd1, 32'h1, 1, 5'd12, 32'hC12);
        tick();
        apply(1, 5'd2, 32'h2, 1, 5'd13, 32'hC13);
        tick();
        chk_out("mrst0", 1'b1, 5'd2, 32'h2, 32'h0000_3000);
        rst = 1'b1;
        apply(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick();
        chk_out("mrst1", 1'b0, 5'd0, 32'h0, 32'h0);
        chk("mrst1.ready", 32'(bus.mdu_ready), 32'h0);
        rst = 1'b0;
        tick();
        chk_out("mrst2", 1'b0, 5'd0, 32'h0, 32'h0);
        chk("mrst2.ready", 32'(bus.mdu_ready), 32'h1);
        tick();
        chk_out("mrst3", 1'b0, 5'd0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
